// File: rtl/bus_initiator_if.sv
// ---------------------------------------------------------------------------
// bus_initiator_if
// Bundles the command stream, the response stream and the peripheral bus of
// bus_initiator into one interface.
//   command : cmd_valid, cmd_ready, cmd_op[1:0], cmd_addr, cmd_data, cmd_mask
//   response: rsp_valid, rsp_ready, rsp_data, rsp_timeout
//   status  : busy
//   bus     : addr, we, di (initiator -> responder), rdata (responder -> initiator)
// The bus read data is called rdata because "do" is a reserved word in
// SystemVerilog.
// Modports: master = the initiator side, slave = host/responder side.
// ---------------------------------------------------------------------------
interface bus_initiator_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;

    logic              busy;

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        input  rsp_ready, rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy,
        output addr, we, di
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        output rsp_ready, rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy,
        input  addr, we, di
    );
endinterface

// File: rtl/bus_initiator.sv
// ---------------------------------------------------------------------------
// bus_initiator
// Command-driven master for the peripheral bus. Takes WRITE / READ / POLL /
// WAIT commands on a valid/ready stream, runs the bus cycles itself and
// returns exactly one response per command.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high; aborts any command in flight
//   bus  - bus_initiator_if.master: command stream, response stream, busy,
//          and the registered bus outputs addr/we/di plus read data rdata
// Command encoding (cmd_op): 00 WRITE, 01 READ, 10 POLL, 11 WAIT.
// WAIT count is {cmd_mask, cmd_data}; the initiator idles count+1 cycles.
// POLL samples rdata every cycle until (rdata & mask) == (data & mask) or
// POLL_LIMIT samples have failed, in which case rsp_timeout is set.
// ---------------------------------------------------------------------------
module bus_initiator #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int POLL_LIMIT = 10_000_000
) (
    input  logic            clk,
    input  logic            rst,
    bus_initiator_if.master bus
);
    localparam int CNT_W  = $clog2(POLL_LIMIT + 1);
    localparam int WAIT_W = 2 * DATA_W;
    // Failure count at which the next failed sample is the last one allowed.
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_LIMIT - 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_POLL,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   poll_val;
    logic [DATA_W-1:0]   poll_mask;
    logic [CNT_W-1:0]    poll_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept;
    logic                poll_hit;
    logic                poll_expired;
    logic                wait_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = (state == S_IDLE);
        bus.busy      = (state != S_IDLE);
        accept        = bus.cmd_valid && (state == S_IDLE);
        poll_hit      = ((bus.rdata ^ poll_val) & poll_mask) == '0;
        poll_expired  = (poll_cnt == POLL_LAST);
        wait_done     = (wait_cnt == '0);

        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_WRITE: state_nxt = S_WRITE;
                        OP_READ:  state_nxt = S_READ;
                        OP_POLL:  state_nxt = S_POLL;
                        OP_WAIT:  state_nxt = S_WAIT;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WRITE: state_nxt = S_RESP;
            S_READ:  state_nxt = S_RESP;
            S_POLL: begin
                if (poll_hit || poll_expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.addr        <= '0;
            bus.we          <= 1'b0;
            bus.di          <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_timeout <= 1'b0;
            poll_val        <= '0;
            poll_mask       <= '0;
            poll_cnt        <= '0;
            wait_cnt        <= '0;
        end else begin
            // The write strobe is a one-cycle pulse raised only on WRITE accept.
            bus.we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        poll_val        <= bus.cmd_data;
                        poll_mask       <= bus.cmd_mask;
                        poll_cnt        <= '0;
                        wait_cnt        <= {bus.cmd_mask, bus.cmd_data};
                        bus.di          <= bus.cmd_data;
                        bus.we          <= (bus.cmd_op == OP_WRITE);
                        bus.rsp_timeout <= 1'b0;
                        // WAIT carries no address; the bus keeps its last one.
                        if (bus.cmd_op != OP_WAIT) begin
                            bus.addr <= bus.cmd_addr;
                        end
                    end
                end
                S_WRITE: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= bus.di;
                end
                S_READ: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= bus.rdata;
                end
                S_POLL: begin
                    if (poll_hit || poll_expired) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_data    <= bus.rdata;
                        bus.rsp_timeout <= !poll_hit;
                    end else begin
                        poll_cnt <= poll_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (wait_done) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_bus_initiator
// Drives bus_initiator with directed and random commands. A small responder
// models the peripheral bus: addresses with bit 15 clear map onto a 16-byte
// register file (index addr[3:0]); addresses with bit 15 set return a
// free-running tick byte. Expected responses are computed from the command
// semantics when each command is accepted and queued; a monitor pops and
// compares whenever a response is handed over.
// ---------------------------------------------------------------------------
module tb_bus_initiator;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int POLL_LIMIT = 16;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    bus_initiator #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    // Responder
    logic [7:0] rmem [16];
    logic [7:0] tick = 8'd0;
    logic       mem_init;

    always @(posedge clk) begin
        tick <= tick + 8'd1;
        if (mem_init) begin
            for (int i = 0; i < 16; i++) rmem[i] <= 8'(i * 37 + 5);
        end else if (bif.we && !bif.addr[15]) begin
            rmem[bif.addr[3:0]] <= bif.di;
        end
    end
    assign bif.rdata = bif.addr[15] ? tick : rmem[bif.addr[3:0]];

    // Scoreboard state and reference model
    typedef struct {
        logic [7:0] data;
        logic [7:0] chk;
        logic       timeout;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mmem [16];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         rise_cyc = 0;
    int         cons_cyc = 0;
    int         we_cnt = 0;
    int         n_writes = 0;
    int         rr_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected response of one command, evaluated in command order.
    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                   input logic [7:0] d, input logic [7:0] m);
        exp_t e;
        e.data    = 8'h00;
        e.chk     = 8'hFF;
        e.timeout = 1'b0;
        case (op)
            OP_WRITE: begin
                if (!a[15]) mmem[a[3:0]] = d;
                e.data = d;
            end
            OP_READ: begin
                if (a[15]) e.chk = 8'h00;
                else e.data = mmem[a[3:0]];
            end
            OP_POLL: begin
                if (a[15]) begin
                    // tick walks through every residue of the mask within the limit
                    e.data = d;
                    e.chk  = m;
                end else begin
                    e.data    = mmem[a[3:0]];
                    e.timeout = ((e.data ^ d) & m) != 8'h00;
                end
            end
            default: e.data = 8'h00;
        endcase
        return e;
    endfunction

    task automatic finish_now(input string why);
        miscompares++;
        $display("FAIL %s: bound expired, got no progress, expected progress", why);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "aborted");
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] a,
                            input logic [7:0] d, input logic [7:0] m);
        int n;
        n = 0;
        @(negedge clk);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_addr  = a;
        bif.cmd_data  = d;
        bif.cmd_mask  = m;
        while (!bif.cmd_ready) begin
            @(negedge clk);
            n++;
            if (n > 5000) finish_now("cmd_accept");
        end
        @(posedge clk);
        sbq.push_back(model(op, a, d, m));
        if (op == OP_WRITE) n_writes++;
        #1;
        acc_cyc = cyc;
        bif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sbq.size(), 0);
        @(negedge clk);
    endtask

    // Response ready generator
    initial begin
        bif.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0: bif.rsp_ready = 1'b1;
                1: bif.rsp_ready = ($urandom_range(0, 3) != 0);
                default: bif.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        logic       stall_p;
        logic       valid_p;
        logic [7:0] held_data;
        logic       held_to;
        exp_t       e;
        stall_p   = 1'b0;
        valid_p   = 1'b0;
        held_data = 8'h00;
        held_to   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_p = 1'b0;
                valid_p = 1'b0;
            end else begin
                if (bif.we) we_cnt++;
                if (bif.rsp_valid && !valid_p) rise_cyc = cyc;
                if (stall_p) begin
                    check("rsp_hold_valid", bif.rsp_valid, 1);
                    check("rsp_hold_data", bif.rsp_data, held_data);
                    check("rsp_hold_timeout", bif.rsp_timeout, held_to);
                end
                if (bif.rsp_valid && bif.rsp_ready) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("rsp_data", bif.rsp_data & e.chk, e.data & e.chk);
                        check("rsp_timeout", bif.rsp_timeout, e.timeout);
                    end
                    cons_cyc = cyc + 1;
                end
                stall_p   = bif.rsp_valid && !bif.rsp_ready;
                held_data = bif.rsp_data;
                held_to   = bif.rsp_timeout;
                valid_p   = bif.rsp_valid;
            end
        end
    end

    // Watchdog
    initial begin
        #900_000;
        finish_now("global_watchdog");
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bif.busy, 0);
        check({tag, "_cmd_ready"}, bif.cmd_ready, 1);
        check({tag, "_we"}, bif.we, 0);
        check({tag, "_addr"}, bif.addr, 0);
        check({tag, "_rsp_valid"}, bif.rsp_valid, 0);
        check({tag, "_rsp_timeout"}, bif.rsp_timeout, 0);
    endtask

    // Stimulus
    initial begin
        int t0;
        logic [1:0]  op;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  m;

        rst           = 1'b1;
        mem_init      = 1'b1;
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 2'b00;
        bif.cmd_addr  = '0;
        bif.cmd_data  = '0;
        bif.cmd_mask  = '0;
        for (int i = 0; i < 16; i++) mmem[i] = 8'(i * 37 + 5);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        mem_init = 1'b0;
        check_idle_outputs("reset");
        check("reset_di", bif.di, 0);
        check("reset_rsp_data", bif.rsp_data, 0);

        // WRITE: single we pulse right after accept, response one cycle later
        send_cmd(OP_WRITE, 16'h0000, 8'h10, 8'h00);
        @(negedge clk);
        check("write_we_pulse", bif.we, 1);
        check("write_addr", bif.addr, 16'h0000);
        check("write_di", bif.di, 8'h10);
        @(negedge clk);
        check("write_we_end", bif.we, 0);
        check("write_rsp_valid", bif.rsp_valid, 1);
        drain();
        check("write_latency", rise_cyc - acc_cyc, 1);

        // READ back the written byte
        send_cmd(OP_READ, 16'h0000, 8'h00, 8'h00);
        drain();
        check("read_latency", rise_cyc - acc_cyc, 1);

        // Minimum command period with rsp_ready high
        send_cmd(OP_WRITE, 16'h0001, 8'hA5, 8'h00);
        t0 = acc_cyc;
        send_cmd(OP_WRITE, 16'h0002, 8'h5A, 8'h00);
        check("cmd_period", acc_cyc - t0, 3);
        drain();

        // POLL on the tick source: bit 0 set within two samples
        send_cmd(OP_POLL, 16'h8000, 8'h01, 8'h01);
        drain();
        check("poll_hit_fast", (rise_cyc - acc_cyc) <= 2, 1);

        // POLL that never matches: times out after POLL_LIMIT samples
        send_cmd(OP_POLL, 16'h0003, ~mmem[3], 8'h01);
        drain();
        check("poll_timeout_latency", rise_cyc - acc_cyc, POLL_LIMIT);

        // POLL with mask 0 matches on the first sample
        send_cmd(OP_POLL, 16'h0004, 8'hFF, 8'h00);
        drain();
        check("poll_mask0_latency", rise_cyc - acc_cyc, 1);

        // WAIT count 5: six cycles in WAIT
        send_cmd(OP_WAIT, 16'h0000, 8'h05, 8'h00);
        drain();
        check("wait_latency", rise_cyc - acc_cyc, 6);

        // READ with the response stalled, a second command queued behind it
        rr_mode = 2;
        send_cmd(OP_READ, 16'h0002, 8'h00, 8'h00);
        @(negedge clk);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = OP_WRITE;
        bif.cmd_addr  = 16'h0005;
        bif.cmd_data  = 8'h3C;
        bif.cmd_mask  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_cmd_ready", bif.cmd_ready, 0);
        end
        rr_mode = 0;
        send_cmd(OP_WRITE, 16'h0005, 8'h3C, 8'h00);
        check("queued_accept_edge", acc_cyc, cons_cyc + 1);
        drain();

        // Reset in the middle of a POLL aborts it without a response
        send_cmd(OP_POLL, 16'h0006, ~mmem[6], 8'hFF);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        check_idle_outputs("abort");
        repeat (POLL_LIMIT + 4) @(negedge clk);
        check("abort_no_rsp", bif.rsp_valid, 0);

        // Random traffic with a randomly stalled response side
        rr_mode = 1;
        for (int k = 0; k < 150; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            d  = 8'($urandom);
            m  = 8'($urandom);
            case (op)
                OP_WRITE: a[15] = 1'b0;
                OP_POLL: begin
                    if (a[15]) m = m & 8'h0F;
                    else if ($urandom_range(0, 1) == 1) d = mmem[a[3:0]];
                end
                OP_WAIT: begin
                    d = 8'($urandom_range(0, 20));
                    m = 8'h00;
                end
                default: ;
            endcase
            send_cmd(op, a, d, m);
        end
        drain();
        rr_mode = 0;

        check("we_cycles", we_cnt, n_writes);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
